// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between byte producers
//
// Ports:
//   clk          : system clock
//   resetn       : asynchronous active-low reset
//   req_valid    : per-requester byte available
//   req_data     : requester i byte at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_last     : byte closes its message (releases the message lock)
//   req_ready    : combinational accept strobe, at most one bit, IDLE only
//   grant        : registered one-hot owner of the current/last accepted byte
//   uart_tx_en   : registered one-cycle start pulse to uart_tx
//   uart_tx_data : registered byte to uart_tx, held until the next accept
//   uart_tx_busy : busy flag from uart_tx
//
// Optional feature: define UART_TX_ARB_LOCK_EN to keep a multi-byte message
// from one requester contiguous on the line.

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
  input  logic                            uart_tx_busy
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [3:0] TO_LAST = 4'(BUSY_TIMEOUT - 1);
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [PTR_W-1:0]          rr_ptr;
  logic [3:0]                to_cnt;
  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        rot;
  logic                      found;
  logic [PTR_W:0]            sum;
  logic [PTR_W:0]            sum_inc;
  logic [PTR_W-1:0]          winner;
  logic [PTR_W-1:0]          winner_inc;
  logic [PAYLOAD_BITS-1:0]   win_data;
  logic                      accept;
  logic                      advance;

`ifdef UART_TX_ARB_LOCK_EN
  logic                      lock_active;
  logic [PTR_W-1:0]          lock_owner;
  logic                      win_last;

  // While a message is open only its owner may be picked.
  always_comb begin
    eligible = req_valid;
    if (lock_active) begin
      eligible = req_valid & (NUM_REQ'(1) << lock_owner);
    end
  end

  always_comb begin
    win_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == winner) begin
        win_last = req_last[k];
      end
    end
  end

  // The pointer only moves once a message is complete, so a locked owner
  // does not lose its turn position mid-message.
  assign advance = win_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_active <= 1'b0;
      lock_owner  <= '0;
    end else if (accept) begin
      lock_active <= !win_last;
      lock_owner  <= winner;
    end
  end
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign eligible        = req_valid;
  assign advance         = 1'b1;
`endif

  // Rotate eligible right by rr_ptr so bit k stands for requester
  // (rr_ptr + k) mod NUM_REQ; the lowest set bit is the winner.
  always_comb begin
    rot   = NUM_REQ'({eligible, eligible} >> rr_ptr);
    found = 1'b0;
    sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      end
    end
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
    winner = sum[PTR_W-1:0];
  end

  always_comb begin
    sum_inc = {1'b0, winner} + (PTR_W+1)'(1);
    if (sum_inc >= NUM_REQ_W) begin
      sum_inc = sum_inc - NUM_REQ_W;
    end
    winner_inc = sum_inc[PTR_W-1:0];
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == winner) begin
        win_data = req_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // A busy line seen in IDLE belongs to someone else; hold off.
  assign accept    = (state == IDLE) && found && !uart_tx_busy;
  assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = SEND;
      end
      SEND: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // If busy never rises the byte is considered sent, so a missing
        // uart_tx response cannot wedge every producer.
        if (uart_tx_busy) state_next = WAIT_DONE;
        else if (to_cnt == TO_LAST) state_next = IDLE;
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      to_cnt       <= '0;
      grant        <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      state      <= state_next;
      uart_tx_en <= accept;
      if (accept) begin
        uart_tx_data <= win_data;
        grant        <= NUM_REQ'(1) << winner;
        if (advance) rr_ptr <= winner_inc;
      end
      if (state == SEND) begin
        to_cnt <= '0;
      end else if (state == WAIT_BUSY) begin
        to_cnt <= to_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (2- and 3-requester instances)

module tb_uart_tx_arbiter;

  localparam int FRAME   = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic stuck;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  vld [2];
  logic [2:0]  lst [2];
  logic [23:0] dat [2];
  logic        busy [2];

  logic [1:0] rdy_a, gnt_a;
  logic [2:0] rdy_b, gnt_b;
  logic       en_a, en_b;
  logic [7:0] txd_a, txd_b;

  logic [2:0] rdy [2];
  logic [2:0] gnt [2];
  logic       en  [2];
  logic [7:0] txd [2];

  assign rdy[0] = {1'b0, rdy_a};
  assign rdy[1] = rdy_b;
  assign gnt[0] = {1'b0, gnt_a};
  assign gnt[1] = gnt_b;
  assign en[0]  = en_a;
  assign en[1]  = en_b;
  assign txd[0] = txd_a;
  assign txd[1] = txd_b;

  uart_tx_arbiter #(.NUM_REQ(2), .PAYLOAD_BITS(8), .BUSY_TIMEOUT(TIMEOUT)) dut_a (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (vld[0][1:0]),
    .req_data     (dat[0][15:0]),
    .req_last     (lst[0][1:0]),
    .req_ready    (rdy_a),
    .grant        (gnt_a),
    .uart_tx_en   (en_a),
    .uart_tx_data (txd_a),
    .uart_tx_busy (busy[0])
  );

  uart_tx_arbiter #(.NUM_REQ(3), .PAYLOAD_BITS(8), .BUSY_TIMEOUT(TIMEOUT)) dut_b (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (vld[1]),
    .req_data     (dat[1]),
    .req_last     (lst[1]),
    .req_ready    (rdy_b),
    .grant        (gnt_b),
    .uart_tx_en   (en_b),
    .uart_tx_data (txd_b),
    .uart_tx_busy (busy[1])
  );

  // uart_tx stand-in: busy rises the cycle after the start pulse and lasts FRAME cycles.
  int bcnt [2];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt[0] <= 0;
      bcnt[1] <= 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (en[d] && !(d == 0 && stuck)) bcnt[d] <= FRAME;
        else if (bcnt[d] != 0) bcnt[d] <= bcnt[d] - 1;
      end
    end
  end
  assign busy[0] = (bcnt[0] != 0);
  assign busy[1] = (bcnt[1] != 0);

  // Producer queues (index d*3+i, entry {last, byte}) and expected line queues ({grant, byte}).
  logic [8:0]  pq [6][$];
  logic [10:0] sb [2][$];

  task automatic check(string nm, logic [31:0] got, logic [31:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s got=%0h need=%0h", nm, got, need);
    end
  endtask

  task automatic put(int d, int i, logic [7:0] b, logic l);
    pq[d*3+i].push_back({l, b});
  endtask

  task automatic expect_byte(int d, logic [2:0] g, logic [7:0] b);
    sb[d].push_back({g, b});
  endtask

  // Producers: pop the head once its byte was accepted, present the next head.
  logic [2:0] rs [2];
  initial begin
    logic [8:0] h;
    for (int d = 0; d < 2; d++) begin
      vld[d] = '0;
      lst[d] = '0;
      dat[d] = '0;
    end
    forever begin
      @(negedge clk);
      rs[0] = rdy[0];
      rs[1] = rdy[1];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 3; i++) begin
          if (rs[d][i] && pq[d*3+i].size() > 0) void'(pq[d*3+i].pop_front());
          if (pq[d*3+i].size() > 0) begin
            h = pq[d*3+i][0];
            vld[d][i] = 1'b1;
            lst[d][i] = h[8];
            dat[d][i*8 +: 8] = h[7:0];
          end else begin
            vld[d][i] = 1'b0;
            lst[d][i] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every start pulse must match the next expected byte and grant.
  int last_acc [2];
  int gap [2];
  initial begin
    logic [10:0] e;
    last_acc[0] = 0; last_acc[1] = 0;
    gap[0] = 0;      gap[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (resetn) begin
          total++;
          if (!$onehot0(rdy[d])) begin
            bad++;
            $display("FAIL ready_onehot dut%0d got=%b need=at_most_one_bit", d, rdy[d]);
          end
        end
        if (rdy[d] != 0) begin
          gap[d] = cyc - last_acc[d];
          last_acc[d] = cyc;
        end
        if (en[d]) begin
          total++;
          if (sb[d].size() == 0) begin
            bad++;
            $display("FAIL line_byte dut%0d got=%h/%h need=nothing", d, gnt[d], txd[d]);
          end else begin
            e = sb[d].pop_front();
            if ({gnt[d], txd[d]} !== e) begin
              bad++;
              $display("FAIL line_byte dut%0d got=%h/%h need=%h/%h", d, gnt[d], txd[d], e[10:8], e[7:0]);
            end
          end
        end
      end
    end
  end

  task automatic drain(int d, string nm);
    int n;
    n = 0;
    while (sb[d].size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 600) begin
      bad++;
      $display("FAIL %s_timeout got=%0d need=0 bytes left", nm, sb[d].size());
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int k = 0; k < 6; k++) pq[k].delete();
    sb[0].delete();
    sb[1].delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=running need=finished");
    $fatal(1);
  end

  initial begin
    int n;
    resetn = 1'b0;
    stuck  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en",    32'(en_a),  0);
    check("rst_data",  32'(txd_a), 0);
    check("rst_grant", 32'(gnt_a), 0);
    check("rst_ready", 32'(rdy_a), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single byte from requester 0: ready, then one-cycle start pulse.
    expect_byte(0, 3'b001, 8'h41);
    put(0, 0, 8'h41, 1'b1);
    n = 0;
    while (rdy_a == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s1_ready", 32'(rdy_a), 32'h1);
    @(negedge clk);
    check("s1_ready_drop", 32'(rdy_a), 0);
    check("s1_en",    32'(en_a),  1);
    check("s1_data",  32'(txd_a), 32'h41);
    check("s1_grant", 32'(gnt_a), 32'h1);
    @(negedge clk);
    check("s1_en_pulse", 32'(en_a), 0);
    drain(0, "s1");

    // Both requesters always valid: strict alternation from reset.
    do_reset();
    put(0, 0, 8'hA0, 1'b1); put(0, 0, 8'hA0, 1'b1);
    put(0, 1, 8'hB0, 1'b1); put(0, 1, 8'hB0, 1'b1);
    expect_byte(0, 3'b001, 8'hA0);
    expect_byte(0, 3'b010, 8'hB0);
    expect_byte(0, 3'b001, 8'hA0);
    expect_byte(0, 3'b010, 8'hB0);
    drain(0, "s2");
    // accept, en, busy seen, FRAME busy cycles, idle-detect, accept
    check("s2_accept_gap", 32'(gap[0]), 32'(FRAME + 3));

    // Message "41\r" from requester 0 while requester 1 offers 0x55.
    do_reset();
    put(0, 0, 8'h34, 1'b0);
    put(0, 0, 8'h31, 1'b0);
    put(0, 0, 8'h0D, 1'b1);
`ifdef UART_TX_ARB_LOCK_EN
    put(0, 1, 8'h55, 1'b1);
    expect_byte(0, 3'b001, 8'h34);
    expect_byte(0, 3'b001, 8'h31);
    expect_byte(0, 3'b001, 8'h0D);
    expect_byte(0, 3'b010, 8'h55);
`else
    put(0, 1, 8'h55, 1'b1);
    put(0, 1, 8'h55, 1'b1);
    expect_byte(0, 3'b001, 8'h34);
    expect_byte(0, 3'b010, 8'h55);
    expect_byte(0, 3'b001, 8'h31);
    expect_byte(0, 3'b010, 8'h55);
    expect_byte(0, 3'b001, 8'h0D);
`endif
    drain(0, "s3");

    // Busy never rises: WAIT_BUSY gives up after TIMEOUT cycles.
    do_reset();
    stuck = 1'b1;
    put(0, 0, 8'h11, 1'b1);
    put(0, 0, 8'h22, 1'b1);
    expect_byte(0, 3'b001, 8'h11);
    expect_byte(0, 3'b001, 8'h22);
    drain(0, "s4");
    check("s4_timeout_gap", 32'(gap[0]), 32'(TIMEOUT + 2));
    stuck = 1'b0;

    // Reset during WAIT_DONE with an open message (lock set when enabled).
    do_reset();
    put(0, 0, 8'h34, 1'b0);
    expect_byte(0, 3'b001, 8'h34);
    n = 0;
    while (!busy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s5_busy_seen", 32'(busy[0]), 1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("s5_async_en",    32'(en_a),  0);
    check("s5_async_data",  32'(txd_a), 0);
    check("s5_async_grant", 32'(gnt_a), 0);
    check("s5_async_ready", 32'(rdy_a), 0);
    for (int k = 0; k < 6; k++) pq[k].delete();
    sb[0].delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    put(0, 1, 8'h77, 1'b1);
    expect_byte(0, 3'b010, 8'h77);
    drain(0, "s5");

    // Three requesters: after serving 0, pointer is 1; 2 beats 0, then 0, then 2.
    put(1, 0, 8'hC0, 1'b1);
    expect_byte(1, 3'b001, 8'hC0);
    drain(1, "s6a");
    put(1, 0, 8'hC3, 1'b1);
    put(1, 2, 8'hC2, 1'b1);
    put(1, 2, 8'hC4, 1'b1);
    expect_byte(1, 3'b100, 8'hC2);
    expect_byte(1, 3'b001, 8'hC3);
    expect_byte(1, 3'b100, 8'hC4);
    drain(1, "s6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
